// File: rtl/adc_serial_responder.sv
// Serial ADC responder: answers the reader's convert/BUSY/SCLK/SDAT sequence with a captured sample word.
// Define ADC_LEAD_ZEROS_EN to prefix every frame with four zero bits (16-clock read of the real part).
module adc_serial_responder #(
    parameter int DATA_W      = 12,
    parameter int CONV_CYCLES = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_conv_st,
    input  logic              i_sclk,
    input  logic [DATA_W-1:0] i_sample_in,
    output logic              o_busy,
    output logic              o_sdat,
    output logic              o_sample_taken,
    output logic              o_frame_done,
    output logic              o_overrun
);

`ifdef ADC_LEAD_ZEROS_EN
    localparam int LEAD_W = 4;
`else
    localparam int LEAD_W = 0;
`endif
    localparam int FRAME_W = DATA_W + LEAD_W;
    localparam int CONV_W  = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(CONV_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {IDLE, CONV, READY, SHIFT} state_t;

    state_t                 r_state, w_state_nx;
    logic [SYNC_STAGES-1:0] r_conv_sync, r_sclk_sync;
    logic                   r_conv_dly, r_sclk_dly;
    logic                   w_conv_fall, w_sclk_fall;
    logic [FRAME_W-1:0]     r_shift, w_shift_nx;
    logic [CONV_W-1:0]      r_conv_cnt, w_conv_cnt_nx;
    logic [BIT_W-1:0]       r_bit_cnt, w_bit_cnt_nx;
    logic                   r_busy, w_busy_nx;
    logic                   r_sdat, w_sdat_nx;
    logic                   r_taken, w_taken_nx;
    logic                   r_done, w_done_nx;
    logic                   r_overrun, w_overrun_nx;
    logic                   w_start;

    // Both reader lines idle high, so the synchronizers reset to 1 to avoid a false fall at release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_conv_sync <= '1;
            r_sclk_sync <= '1;
            r_conv_dly  <= 1'b1;
            r_sclk_dly  <= 1'b1;
        end else begin
            r_conv_sync[0] <= i_conv_st;
            r_sclk_sync[0] <= i_sclk;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_conv_sync[i] <= r_conv_sync[i-1];
                r_sclk_sync[i] <= r_sclk_sync[i-1];
            end
            r_conv_dly <= r_conv_sync[SYNC_STAGES-1];
            r_sclk_dly <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_conv_fall = r_conv_dly & ~r_conv_sync[SYNC_STAGES-1];
    assign w_sclk_fall = r_sclk_dly & ~r_sclk_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_conv_cnt <= '0;
            r_bit_cnt  <= '0;
            r_busy     <= 1'b0;
            r_sdat     <= 1'b0;
            r_taken    <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_conv_cnt <= w_conv_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_busy     <= w_busy_nx;
            r_sdat     <= w_sdat_nx;
            r_taken    <= w_taken_nx;
            r_done     <= w_done_nx;
            r_overrun  <= w_overrun_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_conv_cnt_nx = r_conv_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_busy_nx     = r_busy;
        w_sdat_nx     = r_sdat;
        w_taken_nx    = 1'b0;
        w_done_nx     = 1'b0;
        w_overrun_nx  = 1'b0;
        w_start       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_conv_fall) w_start = 1'b1;
            end
            CONV: begin
                if (w_conv_fall) w_overrun_nx = 1'b1;
                if (r_conv_cnt == '0) begin
                    w_state_nx   = READY;
                    w_busy_nx    = 1'b0;
                    w_sdat_nx    = r_shift[FRAME_W-1];
                    w_bit_cnt_nx = BIT_LOAD;
                end else begin
                    w_conv_cnt_nx = r_conv_cnt - 1'b1;
                end
            end
            READY, SHIFT: begin
                // A convert request outranks an sclk fall arriving in the same cycle.
                if (w_conv_fall) begin
                    w_start      = 1'b1;
                    w_overrun_nx = (r_state == SHIFT);
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt == '0) begin
                        w_state_nx = IDLE;
                        w_sdat_nx  = 1'b0;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_state_nx   = SHIFT;
                        w_shift_nx   = {r_shift[FRAME_W-2:0], 1'b0};
                        w_sdat_nx    = r_shift[FRAME_W-2];
                        w_bit_cnt_nx = r_bit_cnt - 1'b1;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase

        if (w_start) begin
            w_state_nx    = CONV;
            w_shift_nx    = FRAME_W'(i_sample_in);
            w_taken_nx    = 1'b1;
            w_busy_nx     = 1'b1;
            w_sdat_nx     = 1'b0;
            w_conv_cnt_nx = CONV_LOAD;
        end
    end

    assign o_busy         = r_busy;
    assign o_sdat         = r_sdat;
    assign o_sample_taken = r_taken;
    assign o_frame_done   = r_done;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: reset, framing, sample hold, overrun and abort.
// Build with ADC_LEAD_ZEROS_EN defined to exercise the 16-bit frame variant.
module tb_adc_serial_responder;

`ifdef ADC_LEAD_ZEROS_EN
    localparam int   FRAME_BITS  = 16;
    localparam logic READY_MSB   = 1'b0;
    localparam logic [31:0] ABORT_PARTIAL = 32'h01;
`else
    localparam int   FRAME_BITS  = 12;
    localparam logic READY_MSB   = 1'b1;
    localparam logic [31:0] ABORT_PARTIAL = 32'h10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        convSt = 1'b0;
    logic        sclk = 1'b1;
    logic [11:0] sampleIn = '0;
    logic        busy, sdat, sampleTaken, frameDone, overrun;

    int checkCount = 0;
    int passCount = 0;
    int takenCount = 0;
    int doneCount = 0;
    int overrunCount = 0;
    int doneBefore;
    logic [31:0] word;

    adc_serial_responder #(
        .DATA_W(12),
        .CONV_CYCLES(100),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_conv_st(convSt),
        .i_sclk(sclk),
        .i_sample_in(sampleIn),
        .o_busy(busy),
        .o_sdat(sdat),
        .o_sample_taken(sampleTaken),
        .o_frame_done(frameDone),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    // Every high cycle of a pulse output is counted, so stretched pulses show up too.
    always @(posedge clk) begin
        if (sampleTaken) takenCount++;
        if (frameDone) doneCount++;
        if (overrun) overrunCount++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic conv, input logic sc, input logic [11:0] sample);
        convSt   = conv;
        sclk     = sc;
        sampleIn = sample;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Conversion request: the fall is seen after two sync stages, the capture lands one cycle later.
    task automatic startConversion(input logic [11:0] sample, input string tag);
        applyStimulus(1'b0, sclk, sample);
        tick(2);
        checkOutput({tag, "_taken_early"}, {31'b0, sampleTaken}, 32'd0);
        tick(1);
        checkOutput({tag, "_taken"}, {31'b0, sampleTaken}, 32'd1);
        checkOutput({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
        convSt = 1'b1;
        tick(1);
        checkOutput({tag, "_taken_pulse"}, {31'b0, sampleTaken}, 32'd0);
    endtask

    task automatic waitBusyEnd(input int ticksToLastBusy, input string tag);
        tick(ticksToLastBusy);
        checkOutput({tag, "_busy_last"}, {31'b0, busy}, 32'd1);
        tick(1);
        checkOutput({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
    endtask

    // Each bit is taken at the end of the high phase, just before the fall that advances it.
    task automatic readBits(input int n, output logic [31:0] result);
        result = '0;
        for (int i = 0; i < n; i++) begin
            result = {result[30:0], sdat};
            sclk = 1'b0;
            tick(10);
            sclk = 1'b1;
            tick(10);
        end
    endtask

    initial begin
        $display("[TB] start, frame length %0d bits", FRAME_BITS);

        applyStimulus(1'b0, 1'b1, 12'h000);
        for (int i = 0; i < 5; i++) begin
            sclk = ~sclk;
            tick(1);
        end
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_sdat", {31'b0, sdat}, 32'd0);
        checkOutput("rst_pulses", takenCount + doneCount + overrunCount, 32'd0);
        applyStimulus(1'b1, 1'b1, 12'h000);
        rst = 1'b0;
        tick(6);
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("idle_sdat", {31'b0, sdat}, 32'd0);
        checkOutput("idle_pulses", takenCount + doneCount + overrunCount, 32'd0);

        startConversion(12'hA5C, "basic");
        waitBusyEnd(98, "basic");
        checkOutput("basic_ready_sdat", {31'b0, sdat}, {31'b0, READY_MSB});
        readBits(FRAME_BITS, word);
        checkOutput("basic_data", word, 32'hA5C);
        checkOutput("basic_done_cnt", doneCount, 32'd1);
        checkOutput("basic_sdat_end", {31'b0, sdat}, 32'd0);
        checkOutput("basic_taken_cnt", takenCount, 32'd1);
        checkOutput("basic_no_overrun", overrunCount, 32'd0);

        startConversion(12'h001, "hold");
        sampleIn = 12'hFFF;
        waitBusyEnd(98, "hold");
        readBits(FRAME_BITS, word);
        checkOutput("hold_data", word, 32'h001);
        checkOutput("hold_done_cnt", doneCount, 32'd2);

        startConversion(12'h5A3, "ovr");
        tick(35);
        applyStimulus(1'b0, 1'b1, 12'h111);
        tick(3);
        checkOutput("ovr_pulse", {31'b0, overrun}, 32'd1);
        checkOutput("ovr_busy", {31'b0, busy}, 32'd1);
        convSt = 1'b1;
        tick(1);
        checkOutput("ovr_pulse_end", {31'b0, overrun}, 32'd0);
        checkOutput("ovr_no_retake", takenCount, 32'd3);
        waitBusyEnd(59, "ovr");
        readBits(FRAME_BITS, word);
        checkOutput("ovr_data", word, 32'h5A3);
        checkOutput("ovr_cnt", overrunCount, 32'd1);

        startConversion(12'h800, "abort");
        waitBusyEnd(98, "abort");
        readBits(5, word);
        checkOutput("abort_partial", word, ABORT_PARTIAL);
        doneBefore = doneCount;
        applyStimulus(1'b0, 1'b0, 12'h3FF);
        tick(3);
        checkOutput("abort_overrun", {31'b0, overrun}, 32'd1);
        checkOutput("abort_taken", {31'b0, sampleTaken}, 32'd1);
        checkOutput("abort_busy", {31'b0, busy}, 32'd1);
        convSt = 1'b1;
        tick(1);
        checkOutput("abort_overrun_end", {31'b0, overrun}, 32'd0);
        tick(3);
        sclk = 1'b1;
        waitBusyEnd(95, "abort");
        checkOutput("abort_no_done", doneCount, doneBefore);
        readBits(FRAME_BITS, word);
        checkOutput("abort_data", word, 32'h3FF);
        checkOutput("abort_done_cnt", doneCount, doneBefore + 1);

        startConversion(12'hFFF, "full");
        waitBusyEnd(98, "full");
`ifdef ADC_LEAD_ZEROS_EN
        checkOutput("lead_ready_sdat", {31'b0, sdat}, 32'd0);
        readBits(16, word);
        checkOutput("lead_data", word, 32'h0FFF);
`else
        checkOutput("full_ready_sdat", {31'b0, sdat}, 32'd1);
        readBits(12, word);
        checkOutput("full_data", word, 32'hFFF);
`endif
        checkOutput("full_done_cnt", doneCount, doneBefore + 2);
        checkOutput("full_sdat_end", {31'b0, sdat}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/adc_serial_responder.md
Name: adc_serial_responder

Overview:
- Behavioural stand-in for the serial ADC. It answers the ADC reader's convert/BUSY/SCLK/SDAT sequence from the FPGA side.
- Lets the FSK receive chain run in loopback: a 12-bit sample word (e.g. FSK generator output) goes out over the same pins the real ADC would use.
- Sits between a sample source and the JC7..JC10 pin group. It is the responder end of the ADC_95 protocol.

Parameters:
DATA_W, 12, sample width in bits
CONV_CYCLES, 100, clk cycles BUSY stays high per conversion (2 us at 50 MHz)
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on conv_st and sclk

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
conv_st  input  1  convert-start from the reader; conversion starts on falling edge
sclk  input  1  serial clock driven by the reader
sample_in  input  DATA_W  sample captured at conversion start
busy  output  1  high while converting
sdat  output  1  serial data, MSB first
sample_taken  output  1  one-cycle pulse when sample_in is latched
frame_done  output  1  one-cycle pulse after the last data bit is shifted
overrun  output  1  one-cycle pulse when a convert request collides with a conversion or a readout

Behaviour:
Reset:
- rst=1 forces state IDLE, busy=0, sdat=0, all pulses 0, shift register and counters 0.
- Synchronizer flops reset to 1 (idle-high lines).
- Reset mid-conversion or mid-readout abandons the frame with no pulse.

Input handling:
- conv_st and sclk each pass through a SYNC_STAGES synchronizer.
- Edges are detected on the synchronized value against its one-cycle-delayed copy.
- "Edge at cycle N" below means the detector fires in cycle N.

FSM states: IDLE, CONV, READY, SHIFT.
- IDLE/READY + conv_st fall at N:
  - At N+1: shift_reg <= sample_in, sample_taken=1, busy=1, conv counter loaded with CONV_CYCLES-1, state CONV.
- CONV:
  - Counter decrements each cycle.
  - Counter at 0: busy=0 next cycle, sdat=shift_reg MSB, bit counter=DATA_W-1, state READY.
  - BUSY is high for exactly CONV_CYCLES cycles.
- READY: waits for sclk activity. A first sclk fall moves to SHIFT and applies the shift rule below.
- SHIFT: on each sclk falling edge:
  - shift left, sdat = new MSB, bit counter decrements.
  - Data is stable around the reader's rising-edge sample point.
- After the falling edge that follows the LSB (DATA_W falls in total):
  - sdat=0, frame_done=1 for one cycle, state IDLE.
- sclk rising edges change nothing. sclk activity in IDLE or CONV is ignored.

Collisions:
- conv_st fall in CONV: ignored, overrun=1; conversion continues.
- conv_st fall in SHIFT: readout aborted, overrun=1, new conversion starts exactly as from IDLE.
- conv_st fall and sclk fall in the same cycle: conv_st wins.
- sample_in is sampled only at the capture cycle; later changes do not affect the frame.

Optional Feature:
Macro ADC_LEAD_ZEROS_EN.
- Defined: the frame is DATA_W+4 bits. Four leading zeros precede the MSB, matching the real part's 16-clock read.
  - In READY, sdat=0.
  - The MSB appears after the 4th sclk fall.
  - frame_done follows the (DATA_W+4)th fall.
- Undefined: DATA_W-bit frame exactly as in Behaviour.

Test Plan:
- Reset: rst=1 for 5 cycles while sclk toggles and conv_st=0 -> busy=0, sdat=0, no pulses; after release and idle-high inputs, state IDLE.
- Basic frame: sample_in=0xA5C, conv_st pulsed low -> sample_taken at N+1, busy high exactly 100 cycles, then 12 sclk periods (20-cycle period) -> bits 1010_0101_1100 MSB first on rising edges, frame_done once, sdat=0.
- Sample hold: sample_in=0x001 at capture, changed to 0xFFF during CONV -> serialized value is 0x001.
- Overrun in CONV: second conv_st fall at cycle 40 of conversion -> overrun pulse, busy still drops after 100 total cycles, data = first sample.
- Abort in SHIFT: conv_st fall after 5 bits of 0x800, sample_in=0x3FF -> overrun, new BUSY of 100 cycles, next frame reads 0x3FF, no frame_done for the aborted frame.
- ADC_LEAD_ZEROS_EN defined, sample_in=0xFFF -> 16 bits read 0000_1111_1111_1111, frame_done after the 16th fall.
